// File: rtl/kicp_mem_pkg.sv
// Shared definitions for the SRAM port arbiter: op codes, FSM encoding and
// default address width of the RAM256-class macro.
package kicp_mem_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  localparam int KICP_SRAM_AWIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // 2'b10 is reserved and treated as no request.
  function automatic logic op_is_req(input logic [1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks one requester, either round-robin starting
// after ptr or fixed priority with channel 0 highest.
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [2:0]     ptr,
  input  logic           rr_mode,
  output logic           valid,
  output logic [2:0]     win_id
);

  always_comb begin
    int best;
    int rank;
    valid  = 1'b0;
    win_id = '0;
    best   = NCH;
    rank   = 0;
    // Rank is the distance from the slot after ptr; lowest rank wins.
    for (int c = 0; c < NCH; c++) begin
      rank = rr_mode ? ((c + 2 * NCH - int'(ptr) - 1) % NCH) : c;
      if (req[c] && (rank < best)) begin
        best   = rank;
        win_id = 3'(c);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// N-channel arbiter/sequencer sharing one single-port SRAM macro between DMA
// masters. One access at a time: IDLE -> ISSUE -> [WAIT x RD_LAT] -> DONE.
// Handshake: a channel holds req_op (01 read / 11 write) until it sees its
// done bit, and must drop req_op on the clock edge that ends the done cycle.
module sram_port_arbiter
  import kicp_mem_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int AW     = KICP_SRAM_AWIDTH,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int RR_EN  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*NCH-1:0]        req_op,
  input  logic [AW*NCH-1:0]       req_addr,
  input  logic [DW*NCH-1:0]       req_wdata,
  input  logic [(DW/8)*NCH-1:0]   req_sel,
  output logic [NCH-1:0]          done,
  output logic [DW-1:0]           rdata,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    sram_en,
  output logic [(DW/8)-1:0]       sram_we,
  output logic [AW-1:0]           sram_addr,
  output logic [DW-1:0]           sram_di,
  input  logic [DW-1:0]           sram_do,
  output logic [1:0]              dbg_state
);

  localparam int NB = DW / 8;

  arb_state_t    state_q, state_d;
  logic [2:0]    ptr_q;
  logic [2:0]    grant_q;
  logic [1:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [NB-1:0] sel_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    lat_q;

  logic [NCH-1:0] req_vld;
  logic           arb_valid;
  logic [2:0]     arb_id;
  logic [1:0]     win_op;
  logic [AW-1:0]  win_addr;
  logic [DW-1:0]  win_wdata;
  logic [NB-1:0]  win_sel;

  always_comb begin
    req_vld = '0;
    for (int c = 0; c < NCH; c++) begin
      req_vld[c] = op_is_req(req_op[2*c +: 2]);
    end
  end

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (req_vld),
    .ptr     (ptr_q),
    .rr_mode (RR_EN != 0),
    .valid   (arb_valid),
    .win_id  (arb_id)
  );

  always_comb begin
    win_op    = MEM_OP_NONE;
    win_addr  = '0;
    win_wdata = '0;
    win_sel   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (arb_id == 3'(c)) begin
        win_op    = req_op[2*c +: 2];
        win_addr  = req_addr[AW*c +: AW];
        win_wdata = req_wdata[DW*c +: DW];
        win_sel   = req_sel[NB*c +: NB];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = (op_q == MEM_OP_WRITE) ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (lat_q == 2'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'(NCH - 1);
      grant_q <= '0;
      op_q    <= MEM_OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_id;
            op_q    <= win_op;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            sel_q   <= win_sel;
            if (RR_EN != 0) ptr_q <= arb_id;
          end
        end
        ST_ISSUE: lat_q <= 2'(RD_LAT - 1);
        ST_WAIT: begin
          // Do is valid during the last WAIT cycle of the latency window.
          if (lat_q == 2'd0) rdata_q <= sram_do;
          else               lat_q   <= lat_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done = '0;
    for (int c = 0; c < NCH; c++) begin
      done[c] = (state_q == ST_DONE) && (grant_q == 3'(c));
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign sram_en   = (state_q == ST_ISSUE);
  assign sram_we   = ((state_q == ST_ISSUE) && (op_q == MEM_OP_WRITE)) ? sel_q : '0;
  assign sram_addr = addr_q;
  assign sram_di   = wdata_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: dut a (round-robin, RD_LAT=1) and dut b
// (fixed priority, RD_LAT=3), each with its own behavioural SRAM.
module tb_sram_port_arbiter;

  localparam int NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, mem_clr;

  logic [7:0]   a_req_op,    b_req_op;
  logic [31:0]  a_req_addr,  b_req_addr;
  logic [127:0] a_req_wdata, b_req_wdata;
  logic [15:0]  a_req_sel,   b_req_sel;
  logic [3:0]   a_done,  b_done;
  logic [31:0]  a_rdata, b_rdata;
  logic [2:0]   a_gid,   b_gid;
  logic         a_busy,  b_busy;
  logic         a_en,    b_en;
  logic [3:0]   a_we,    b_we;
  logic [7:0]   a_addr,  b_addr;
  logic [31:0]  a_di,    b_di;
  logic [31:0]  a_do,    b_do;
  logic [1:0]   a_dbg,   b_dbg;

  sram_port_arbiter #(.NCH(4), .AW(8), .DW(32), .RD_LAT(1), .RR_EN(1)) u_dut_a (
    .clk(clk), .reset(rst_a), .req_op(a_req_op), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_sel(a_req_sel), .done(a_done), .rdata(a_rdata),
    .grant_id(a_gid), .busy(a_busy), .sram_en(a_en), .sram_we(a_we),
    .sram_addr(a_addr), .sram_di(a_di), .sram_do(a_do), .dbg_state(a_dbg)
  );

  sram_port_arbiter #(.NCH(4), .AW(8), .DW(32), .RD_LAT(3), .RR_EN(0)) u_dut_b (
    .clk(clk), .reset(rst_b), .req_op(b_req_op), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_sel(b_req_sel), .done(b_done), .rdata(b_rdata),
    .grant_id(b_gid), .busy(b_busy), .sram_en(b_en), .sram_we(b_we),
    .sram_addr(b_addr), .sram_di(b_di), .sram_do(b_do), .dbg_state(b_dbg)
  );

  // Behavioural SRAMs: Do carries a poison word unless a read was issued
  // exactly RD_LAT cycles earlier.
  logic [31:0] a_mem [256];
  logic [31:0] b_mem [256];
  logic [31:0] a_pipe;
  logic [31:0] b_pipe [3];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) a_mem[i] <= '0;
    end else if (a_en) begin
      for (int l = 0; l < 4; l++) if (a_we[l]) a_mem[a_addr][8*l +: 8] <= a_di[8*l +: 8];
    end
    a_pipe <= (a_en && a_we == 4'h0) ? a_mem[a_addr] : 32'h0BAD_F00D;
  end
  assign a_do = a_pipe;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) b_mem[i] <= '0;
    end else if (b_en) begin
      for (int l = 0; l < 4; l++) if (b_we[l]) b_mem[b_addr][8*l +: 8] <= b_di[8*l +: 8];
    end
    b_pipe[0] <= (b_en && b_we == 4'h0) ? b_mem[b_addr] : 32'h0BAD_F00D;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_do = b_pipe[2];

  int          cur;
  logic [3:0]  m_done;
  logic [31:0] m_rdata, m_di;
  logic [2:0]  m_gid;
  logic        m_busy, m_en;
  logic [3:0]  m_we;
  logic [7:0]  m_addr;

  always_comb begin
    if (cur == 0) begin
      m_done = a_done; m_rdata = a_rdata; m_gid = a_gid; m_busy = a_busy;
      m_en = a_en; m_we = a_we; m_addr = a_addr; m_di = a_di;
    end else begin
      m_done = b_done; m_rdata = b_rdata; m_gid = b_gid; m_busy = b_busy;
      m_en = b_en; m_we = b_we; m_addr = b_addr; m_di = b_di;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  logic [31:0] exp_mem [2][256];
  int          mdl_ptr [2];
  logic [31:0] mdl_rdata [2];
  bit          mdl_rr [2];
  int          mdl_lat [2];

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          exp_g;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // First requester (01 or 11) met when scanning from the slot after the
  // previous winner (round-robin) or from channel 0 (fixed priority).
  function automatic int mdl_winner(input logic [7:0] op, input int ptr, input bit rr);
    for (int k = 0; k < NCH; k++) begin
      int c;
      logic [7:0] code;
      c = rr ? ((ptr + 1 + k) % NCH) : k;
      code = (op >> (2 * c)) & 8'h3;
      if (code == 8'h1 || code == 8'h3) return c;
    end
    return -1;
  endfunction

  task automatic drive(input int which, input logic [7:0] op, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] sel);
    if (which == 0) begin
      a_req_op = op; a_req_addr = {4{addr}}; a_req_wdata = {4{wd}}; a_req_sel = {4{sel}};
    end else begin
      b_req_op = op; b_req_addr = {4{addr}}; b_req_wdata = {4{wd}}; b_req_sel = {4{sel}};
    end
  endtask

  task automatic do_txn(input int which, input logic [7:0] op, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] sel, input int tbl_g,
                        input bit chk_rd, input logic [31:0] tbl_rd, input string name);
    int g, exp_lat, en_cnt, k;
    bit wr, got;
    logic [31:0] exp_rd;
    logic [2:0] q_g;
    cur = which;
    g = mdl_winner(op, mdl_ptr[which], mdl_rr[which]);
    if (tbl_g >= 0) g = tbl_g;
    wr = (((op >> (2 * g)) & 8'h3) == 8'h3);
    exp_lat = wr ? 2 : 2 + mdl_lat[which];
    exp_rd = wr ? mdl_rdata[which] : exp_mem[which][addr];
    if (chk_rd) exp_rd = tbl_rd;
    exp_q.push_back(3'(g));
    drive(which, op, addr, wd, sel);
    en_cnt = 0; got = 1'b0; k = 0;
    while (!got && k < 16) begin
      step;
      k++;
      en_cnt += int'(m_en);
      if (k == 1) begin
        chk({name, " issue_addr"}, 32'(m_addr), 32'(addr));
        chk({name, " issue_we"}, 32'(m_we), wr ? 32'(sel) : 32'h0);
        chk({name, " grant_id"}, 32'(m_gid), 32'(g));
        if (wr) chk({name, " issue_di"}, m_di, wd);
      end
      if (m_done != 4'h0) got = 1'b1;
    end
    q_g = exp_q.pop_front();
    chk({name, " done"}, 32'(m_done), 32'(1) << q_g);
    chk({name, " latency"}, 32'(k), 32'(exp_lat));
    chk({name, " en_cycles"}, 32'(en_cnt), 32'd1);
    chk({name, " rdata"}, m_rdata, exp_rd);
    if (wr) begin
      for (int l = 0; l < 4; l++) if (sel[l]) exp_mem[which][addr][8*l +: 8] = wd[8*l +: 8];
    end else begin
      mdl_rdata[which] = exp_rd;
    end
    if (mdl_rr[which]) mdl_ptr[which] = g;
    drive(which, 8'h00, addr, wd, sel);
    step;
    chk({name, " idle_after"}, {m_busy, m_done}, 5'h0);
    chk({name, " gid_hold"}, 32'(m_gid), 32'(g));
  endtask

  task automatic idle_check(input int which, input logic [7:0] op, input int n, input string name);
    cur = which;
    drive(which, op, 8'h00, 32'h0, 4'h0);
    for (int i = 0; i < n; i++) begin
      step;
      chk({name, " no_activity"}, {m_busy, m_en, m_done}, 6'h0);
    end
    drive(which, 8'h00, 8'h00, 32'h0, 4'h0);
  endtask

  task automatic chk_reset_outputs(input int which, input string name);
    cur = which;
    chk({name, " done"}, 32'(m_done), 0);
    chk({name, " rdata"}, m_rdata, 0);
    chk({name, " gid_busy_en"}, {m_gid, m_busy, m_en}, 0);
    chk({name, " we_addr"}, {m_we, m_addr}, 0);
    chk({name, " di"}, m_di, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] rop;
    tbl[0]  = '{8'h55, 8'h40, 32'h0,         4'h0, 0, 1'b1, 32'h0};
    tbl[1]  = '{8'h55, 8'h40, 32'h0,         4'h0, 1, 1'b1, 32'h0};
    tbl[2]  = '{8'h55, 8'h40, 32'h0,         4'h0, 2, 1'b1, 32'h0};
    tbl[3]  = '{8'h55, 8'h40, 32'h0,         4'h0, 3, 1'b1, 32'h0};
    tbl[4]  = '{8'h55, 8'h40, 32'h0,         4'h0, 0, 1'b1, 32'h0};
    tbl[5]  = '{8'h03, 8'h12, 32'hDEADBEEF,  4'hF, 0, 1'b1, 32'h0};
    tbl[6]  = '{8'h01, 8'h12, 32'h0,         4'h0, 0, 1'b1, 32'hDEADBEEF};
    tbl[7]  = '{8'h0C, 8'h20, 32'hFFFFFFFF,  4'hF, 1, 1'b1, 32'hDEADBEEF};
    tbl[8]  = '{8'h0C, 8'h20, 32'h00000000,  4'h5, 1, 1'b1, 32'hDEADBEEF};
    tbl[9]  = '{8'h04, 8'h20, 32'h0,         4'h0, 1, 1'b1, 32'hFF00FF00};
    tbl[10] = '{8'h30, 8'h30, 32'h12345678,  4'h0, 2, 1'b1, 32'hFF00FF00};
    tbl[11] = '{8'h10, 8'h30, 32'h0,         4'h0, 2, 1'b1, 32'h0};
    tbl[12] = '{8'h06, 8'h12, 32'h0,         4'h0, 1, 1'b1, 32'hDEADBEEF};

    for (int i = 0; i < 256; i++) begin
      exp_mem[0][i] = '0;
      exp_mem[1][i] = '0;
    end
    mdl_ptr   = '{NCH - 1, NCH - 1};
    mdl_rdata = '{32'h0, 32'h0};
    mdl_rr    = '{1'b1, 1'b0};
    mdl_lat   = '{1, 3};

    // Reset held two cycles with ch1 requesting a write.
    rst_a = 1'b1; rst_b = 1'b1; mem_clr = 1'b1; cur = 0;
    drive(0, 8'h0C, 8'h12, 32'hCAFEF00D, 4'hF);
    drive(1, 8'h0C, 8'h12, 32'hCAFEF00D, 4'hF);
    step;
    chk_reset_outputs(0, "reset_a_c1");
    chk_reset_outputs(1, "reset_b_c1");
    step;
    chk_reset_outputs(0, "reset_a_c2");
    chk_reset_outputs(1, "reset_b_c2");
    rst_a = 1'b0; rst_b = 1'b0; mem_clr = 1'b0;
    drive(0, 8'h00, 8'h00, 32'h0, 4'h0);
    drive(1, 8'h00, 8'h00, 32'h0, 4'h0);
    step;
    chk_reset_outputs(0, "post_reset_a");

    for (int i = 0; i < 13; i++) begin
      do_txn(0, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].sel, tbl[i].exp_g,
             tbl[i].chk_rd, tbl[i].exp_rd, $sformatf("tbl%0d", i));
    end

    idle_check(0, 8'hAA, 4, "illegal_ops_a");

    for (int i = 0; i < 3; i++) do_txn(1, 8'h55, 8'h40, 32'h0, 4'h0, 0, 1'b1, 32'h0, "fp_all_rd");
    do_txn(1, 8'hC0, 8'h05, 32'hA5A50001, 4'hF, 3, 1'b1, 32'h0, "fp_ch3_wr");
    do_txn(1, 8'h40, 8'h05, 32'h0, 4'h0, 3, 1'b1, 32'hA5A50001, "lat3_ch3_rd");
    do_txn(1, 8'hCC, 8'h07, 32'h11223344, 4'h9, 1, 1'b1, 32'hA5A50001, "fp_ch1_ch3_wr");
    do_txn(1, 8'h01, 8'h07, 32'h0, 4'h0, 0, 1'b1, 32'h11000044, "lat3_lanes_rd");

    // Reset lands in the middle of the RD_LAT=3 wait window.
    cur = 1;
    drive(1, 8'h01, 8'h05, 32'h0, 4'h0);
    step;
    step;
    chk("abort busy_in_wait", 32'(b_busy), 32'd1);
    rst_b = 1'b1;
    drive(1, 8'h00, 8'h00, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("abort no_done", 32'(b_done), 32'h0);
    end
    rst_b = 1'b0;
    step;
    chk("abort idle", {b_busy, b_done, b_en}, 6'h0);
    chk("abort rdata_cleared", b_rdata, 32'h0);
    mdl_rdata[1] = 32'h0;
    mdl_ptr[1] = NCH - 1;
    do_txn(1, 8'h30, 8'h06, 32'h600D0002, 4'hF, 2, 1'b0, 32'h0, "abort_next_wr");
    do_txn(1, 8'h10, 8'h06, 32'h0, 4'h0, 2, 1'b1, 32'h600D0002, "abort_next_rd");

    for (int n = 0; n < 60; n++) begin
      int which;
      which = (n < 40) ? 0 : 1;
      for (int c = 0; c < NCH; c++) rop[2*c +: 2] = 2'($urandom_range(0, 3));
      if (mdl_winner(rop, mdl_ptr[which], mdl_rr[which]) < 0) begin
        idle_check(which, rop, 3, "rand_idle");
      end else begin
        do_txn(which, rop, 8'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
               -1, 1'b0, 32'h0, $sformatf("rand%0d", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
